trees_prediction_packer: RTL and testbench
==========================================

# trees_prediction_packer

Per-sample prediction collector for the tree accelerator. It accepts one 8-bit class prediction per sample from the tree evaluation core and packs eight predictions into each 64-bit word, little-endian by byte lane. The packed words are held in a local buffer. The DMA write sequencer reads them back by word index and streams them to memory, ceil(burst_len/8) words per burst.

## Interface
- MAX_BURST, 5000, maximum samples per burst. Buffer depth DEPTH = ceil(MAX_BURST/8) words of 64 bits.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  single-cycle pulse; starts a new burst and latches burst_len
- burst_len  in  32  number of predictions expected in the burst; sampled only when clear=1
- pred_valid  in  1  prediction offered
- pred_data  in  8  class prediction
- pred_ready  out  1  packer accepts the offered prediction
- rd_addr  in  32  word index requested by the DMA write side
- rd_data  out  64  packed word at rd_addr
- count  out  32  predictions accepted in the current burst
- done  out  1  all burst_len predictions stored; held until the next clear
- error  out  1  sticky fault flag; cleared by clear or reset

## Operation
- States: IDLE, COLLECT, DONE. Handshake: pred_valid & pred_ready.
- pred_ready = (state == COLLECT), combinational from state.
- Registers: latched length len, count, a 64-bit staging word, and mem[DEPTH]. mem is not reset.
- clear in any state:
  - count <= 0, staging <= 0, done <= 0, error <= 0.
  - burst_len == 0: go to DONE with done <= 1.
  - burst_len > MAX_BURST: error <= 1, go to IDLE.
  - Otherwise: len <= burst_len, go to COLLECT.
- COLLECT handshake, with lane = count[2:0]:
  - merged = staging with byte lane `lane` replaced by pred_data.
  - count <= count + 1.
  - If lane == 7 or count == len-1: mem[count>>3] <= merged, staging <= 0.
  - Otherwise: staging <= merged.
  - If count == len-1: done <= 1, go to DONE.
- Lanes above the last sample in the final partial word read as zero, because staging starts at zero.
- Fault: pred_valid=1 in IDLE or DONE with clear=0 sets error <= 1. The data is dropped and mem is unchanged.
- clear and pred_valid in the same cycle: clear wins and the sample is dropped. No error is flagged.
- rd_data = mem[rd_addr] when rd_addr < DEPTH, else 64'd0. Asynchronous read, no latency.
- Words at index >= ceil(len/8) hold stale contents from earlier bursts.
- count is 32-bit. With len <= MAX_BURST, count never wraps.

## Timing
- Reset values:
  - state IDLE, pred_ready 0, count 0, done 0, error 0, staging 0.
  - rd_data is undefined until the addressed word has been written; benches must not check it before then.
- Throughput: one prediction per cycle; back-to-back handshakes are supported.
- A word is visible on rd_data the cycle after the handshake that completes it.
- done rises the cycle after the final handshake. pred_ready falls in that same cycle.
- clear takes effect at the next edge:
  - pred_ready reflects the new state one cycle after clear.
  - done/error clear one cycle after clear.
  - A zero-length burst shows done=1 one cycle after clear.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. Partially written mem contents persist.

## Test plan
- Full word: clear with burst_len=8, then 0x01..0x08 back-to-back.
  - pred_ready high for exactly 8 cycles; done=1 the cycle after the 8th handshake; count=8.
  - rd_addr=0 gives 0x0807060504030201.
- Partial word with gaps: burst_len=11, values 0xA0..0xAA, pred_valid toggled every other cycle.
  - word0 = 0xA7A6A5A4A3A2A1A0, word1 = 0x0000000000AAA9A8; count=11; done=1.
- Zero and oversize lengths:
  - burst_len=0: done=1 one cycle after clear, pred_ready stays 0, error=0.
  - burst_len=MAX_BURST+1: error=1, state IDLE, pred_ready=0, done=0.
- Overflow and collision:
  - pred_valid=1 in DONE: error=1, rd_data of all words unchanged.
  - pred_valid together with clear (burst_len=8): count=0 afterwards, error=0.
- Reset and reuse:
  - rst low after 5 samples of an 8-sample burst: count=0, done=0, pred_ready=0.
  - Then clear with burst_len=8 and 0x11..0x18: word0 = 0x1817161514131211.
  - rd_addr=DEPTH returns 0.

Source files
------------

// File: rtl/trees_prediction_packer.sv
// trees_prediction_packer
// Collects one 8-bit class prediction per sample and packs eight of them,
// little-endian by byte lane, into 64-bit words held in a local buffer that
// the DMA write side reads back by word index (asynchronous read).
//
// Handshake: a prediction transfers on a rising clk edge where
// pred_valid & pred_ready are both high; pred_ready depends only on the FSM
// state (high only while collecting), so the producer may hold pred_valid
// with stable pred_data until it sees pred_ready.
module trees_prediction_packer #(
   parameter int MAX_BURST = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [31:0] burst_len,
   input  logic        pred_valid,
   input  logic [7:0]  pred_data,
   output logic        pred_ready,
   input  logic [31:0] rd_addr,
   output logic [63:0] rd_data,
   output logic [31:0] count,
   output logic        done,
   output logic        error,
   output logic [1:0]  state_dbg
);

   localparam int DEPTH = (MAX_BURST + 7) / 8;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [31:0]   len, len_next;
   logic [31:0]   count_next;
   logic [63:0]   staging, staging_next;
   logic          done_next, error_next;
   logic [63:0]   merged;
   logic [2:0]    lane;
   logic          last;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [63:0]   mem [DEPTH];

   assign lane       = count[2:0];
   assign last       = (count == len - 32'd1);
   assign mem_waddr  = count[AW+2:3];
   assign pred_ready = (state == ST_COLLECT);
   assign state_dbg  = state;

   // Asynchronous read port; out-of-range indices read as zero.
   assign rd_data = (rd_addr < 32'(DEPTH)) ? mem[rd_addr[AW-1:0]] : 64'd0;

   // State and control/datapath registers, async active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         len     <= 32'd0;
         count   <= 32'd0;
         staging <= 64'd0;
         done    <= 1'b0;
         error   <= 1'b0;
      end else begin
         state   <= state_next;
         len     <= len_next;
         count   <= count_next;
         staging <= staging_next;
         done    <= done_next;
         error   <= error_next;
      end
   end

   // Buffer write port; the buffer itself is never reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= merged;
   end

   // Next-state and datapath decisions; clear overrides everything else.
   always_comb begin
      state_next   = state;
      len_next     = len;
      count_next   = count;
      staging_next = staging;
      done_next    = done;
      error_next   = error;
      mem_we       = 1'b0;
      merged       = staging;
      merged[{lane, 3'b000} +: 8] = pred_data;

      if (clear) begin
         count_next   = 32'd0;
         staging_next = 64'd0;
         done_next    = 1'b0;
         error_next   = 1'b0;
         if (burst_len == 32'd0) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
         end else if (burst_len > 32'(MAX_BURST)) begin
            state_next = ST_IDLE;
            error_next = 1'b1;
         end else begin
            len_next   = burst_len;
            state_next = ST_COLLECT;
         end
      end else begin
         case (state)
            ST_COLLECT: begin
               if (pred_valid) begin
                  count_next = count + 32'd1;
                  if (lane == 3'd7 || last) begin
                     mem_we       = 1'b1;
                     staging_next = 64'd0;
                  end else begin
                     staging_next = merged;
                  end
                  if (last) begin
                     done_next  = 1'b1;
                     state_next = ST_DONE;
                  end
               end
            end
            default: begin
               // A prediction offered while not collecting is a producer fault.
               if (pred_valid) error_next = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trees_prediction_packer.sv
// Bench for trees_prediction_packer: directed scenarios plus randomized
// bursts, checked every cycle against a byte-queue model of the packer.
module tb_trees_prediction_packer;

   localparam int MAX_BURST = 5000;
   localparam int DEPTH     = (MAX_BURST + 7) / 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] burst_len = 32'd0;
   logic        pred_valid = 1'b0;
   logic [7:0]  pred_data = 8'd0;
   logic        pred_ready;
   logic [31:0] rd_addr = 32'd0;
   logic [63:0] rd_data;
   logic [31:0] count;
   logic        done;
   logic        error;
   logic [1:0]  state_dbg;

   int n_vec  = 0;
   int n_miss = 0;

   trees_prediction_packer #(.MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .clear(clear), .burst_len(burst_len),
      .pred_valid(pred_valid), .pred_data(pred_data), .pred_ready(pred_ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .done(done),
      .error(error), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Bytes of the word currently being filled sit in exp_q; a word is
   // committed when eight bytes are present or the burst ends.
   logic [7:0]  exp_q[$];
   logic [63:0] m_mem [DEPTH];
   bit          m_written [DEPTH];
   bit          m_coll  = 0;
   bit          m_done  = 0;
   bit          m_err   = 0;
   int          m_count = 0;
   int          m_len   = 0;

   task automatic model_flush();
      logic [63:0] w;
      w = 64'd0;
      for (int i = 0; i < exp_q.size(); i++) w[i*8 +: 8] = exp_q[i];
      m_mem[(m_count - 1) / 8]     = w;
      m_written[(m_count - 1) / 8] = 1'b1;
      exp_q.delete();
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_coll = 0; m_done = 0; m_err = 0; m_count = 0;
         exp_q.delete();
      end else if (clear) begin
         m_count = 0; m_done = 0; m_err = 0;
         exp_q.delete();
         if (burst_len == 0) begin
            m_coll = 0; m_done = 1;
         end else if (burst_len > MAX_BURST) begin
            m_coll = 0; m_err = 1;
         end else begin
            m_coll = 1; m_len = int'(burst_len);
         end
      end else if (pred_valid) begin
         if (m_coll) begin
            exp_q.push_back(pred_data);
            m_count++;
            if (exp_q.size() == 8 || m_count == m_len) model_flush();
            if (m_count == m_len) begin
               m_coll = 0; m_done = 1;
            end
         end else begin
            m_err = 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare on the falling edge, away from the active edge.
   always @(negedge clk) begin
      check("pred_ready", 64'(pred_ready), 64'(m_coll));
      check("count", 64'(count), 64'(m_count));
      check("done", 64'(done), 64'(m_done));
      check("error", 64'(error), 64'(m_err));
      if (rd_addr >= DEPTH)
         check("rd_data_oob", rd_data, 64'd0);
      else if (m_written[rd_addr])
         check("rd_data", rd_data, m_mem[rd_addr]);
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_clear(input logic [31:0] bl);
      clear = 1'b1; burst_len = bl; pred_valid = 1'b0;
      step();
      clear = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      pred_valid = 1'b1; pred_data = d;
      step();
      pred_valid = 1'b0;
   endtask

   task automatic read_check(input string name, input int addr, input logic [63:0] exp);
      rd_addr = 32'(addr);
      #1;
      check(name, rd_data, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
      step(); step(); step();
      check("rst_count", 64'(count), 64'd0);
      check("rst_ready", 64'(pred_ready), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst = 1'b1;
      step();

      // Full word
      do_clear(32'd8);
      for (int i = 0; i < 8; i++) send(8'(i + 1));
      check("fw_done", 64'(done), 64'd1);
      check("fw_count", 64'(count), 64'd8);
      check("fw_ready", 64'(pred_ready), 64'd0);
      read_check("fw_word0", 0, 64'h0807060504030201);

      // Partial word with gaps
      do_clear(32'd11);
      for (int k = 0; k < 22; k++) begin
         pred_valid = (k % 2 == 0);
         pred_data  = pred_valid ? 8'hA0 + 8'(k / 2) : 8'($urandom);
         step();
      end
      pred_valid = 1'b0;
      step();
      check("pw_count", 64'(count), 64'd11);
      check("pw_done", 64'(done), 64'd1);
      read_check("pw_word0", 0, 64'hA7A6A5A4A3A2A1A0);
      read_check("pw_word1", 1, 64'h0000000000AAA9A8);

      // Zero length
      do_clear(32'd0);
      check("zl_done", 64'(done), 64'd1);
      check("zl_ready", 64'(pred_ready), 64'd0);
      check("zl_error", 64'(error), 64'd0);
      step();
      check("zl_ready2", 64'(pred_ready), 64'd0);

      // Oversize length
      do_clear(32'(MAX_BURST + 1));
      check("ov_error", 64'(error), 64'd1);
      check("ov_ready", 64'(pred_ready), 64'd0);
      check("ov_done", 64'(done), 64'd0);

      // Overflow: offer a prediction in DONE
      do_clear(32'd8);
      for (int i = 0; i < 8; i++) send(8'(8'hC0 + i));
      send(8'hEE);
      check("of_error", 64'(error), 64'd1);
      read_check("of_word0", 0, 64'hC7C6C5C4C3C2C1C0);
      read_check("of_word1", 1, 64'h0000000000AAA9A8);

      // Collision: clear and pred_valid together
      clear = 1'b1; burst_len = 32'd8; pred_valid = 1'b1; pred_data = 8'h55;
      step();
      clear = 1'b0; pred_valid = 1'b0;
      check("col_count", 64'(count), 64'd0);
      check("col_error", 64'(error), 64'd0);
      check("col_ready", 64'(pred_ready), 64'd1);

      // Reset mid-burst, then reuse
      for (int i = 0; i < 5; i++) send(8'($urandom));
      rst = 1'b0;
      step();
      check("mr_count", 64'(count), 64'd0);
      check("mr_done", 64'(done), 64'd0);
      check("mr_ready", 64'(pred_ready), 64'd0);
      rst = 1'b1;
      step();
      do_clear(32'd8);
      for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
      read_check("ru_word0", 0, 64'h1817161514131211);
      read_check("ru_oob", DEPTH, 64'd0);

      // Randomized bursts
      for (int b = 0; b < 60; b++) begin
         int sel;
         logic [31:0] bl;
         sel = $urandom_range(0, 15);
         if (sel == 0)      bl = 32'd0;
         else if (sel == 1) bl = 32'(MAX_BURST + $urandom_range(1, 100));
         else               bl = 32'($urandom_range(1, 40));
         do_clear(bl);
         for (int c = 0; c < 120; c++) begin
            if ($urandom_range(0, 79) == 0) begin
               clear = 1'b1; burst_len = 32'($urandom_range(1, 40));
            end else begin
               clear = 1'b0;
            end
            pred_valid = (m_coll || $urandom_range(0, 15) == 0) && ($urandom_range(0, 3) != 0);
            pred_data  = 8'($urandom);
            rd_addr    = ($urandom_range(0, 9) == 0) ? 32'(DEPTH - 1 + $urandom_range(0, 3))
                                                     : 32'($urandom_range(0, 6));
            step();
            if (!m_coll && c > 4 && !clear) break;
         end
         clear = 1'b0; pred_valid = 1'b0;
         step();
      end

      // One maximum-length burst
      do_clear(32'(MAX_BURST));
      for (int c = 0; c < 7000 && m_coll; c++) begin
         pred_valid = ($urandom_range(0, 7) != 0);
         pred_data  = 8'($urandom);
         rd_addr    = 32'($urandom_range(0, DEPTH + 2));
         step();
      end
      pred_valid = 1'b0;
      step();
      check("max_done", 64'(done), 64'd1);
      check("max_count", 64'(count), 64'(MAX_BURST));
      for (int a = DEPTH - 3; a < DEPTH + 2; a++) begin
         rd_addr = 32'(a);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
